// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port byte-lane BRAM between the Caravel WB slave (port 0)
// and a user req/ack port (port 1); round-robin on ties, programmable response delay.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate pending requests
// ACCESS  | single BRAM enable cycle with the latched command
// CAPTURE | BRAM read data valid; latch it and load the delay timer
// WAIT    | delay timer counts down to terminal count
// RESP    | one-cycle ack to the granted port if it is still requesting

module bram_arbiter #(
    parameter int         DELAYS  = 10,
    parameter logic [7:0] BASE_HI = 8'h38,
    parameter int         ADDR_W  = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [3:0]  p1_be,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    input  logic [31:0] bram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int          CNT_W     = $clog2(DELAYS + 2);
    // Upper bits beyond the memory size alias; the byte offset within a word is dropped.
    localparam logic [31:0] ADDR_MASK = ((32'h1 << ADDR_W) - 32'h1) & ~32'h3;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              grant;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       rdata;

    logic              r0, r1, win;

    assign r0  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
    assign r1  = p1_req;
    // On a tie the port that did not win the previous tie goes first.
    assign win = (r0 & r1) ? ~last_grant : ~r0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (r0 | r1) state_nxt = S_ACCESS;
            S_ACCESS:  state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (DELAYS > 0) ? S_WAIT : S_RESP;
            S_WAIT:    if (cnt == CNT_W'(1)) state_nxt = S_RESP;
            S_RESP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            rdata      <= 32'h0;
            cnt        <= '0;
        end else begin
            if (state == S_IDLE && (r0 | r1)) begin
                grant <= win;
                if (r0 & r1) last_grant <= win;
                if (win) begin
                    r_we    <= p1_we;
                    r_sel   <= p1_be;
                    r_addr  <= p1_addr & ADDR_MASK;
                    r_wdata <= p1_wdata;
                end else begin
                    r_we    <= wbs_we_i;
                    r_sel   <= wbs_sel_i;
                    r_addr  <= wbs_adr_i & ADDR_MASK;
                    r_wdata <= wbs_dat_i;
                end
            end
            if (state == S_CAPTURE) begin
                rdata <= bram_rdata;
                cnt   <= CNT_W'(DELAYS);
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 4'h0;
        bram_addr  = 32'h0;
        bram_wdata = 32'h0;
        wbs_ack_o  = 1'b0;
        p1_ack     = 1'b0;
        if (state == S_ACCESS) begin
            bram_en    = 1'b1;
            bram_we    = r_we ? r_sel : 4'h0;
            bram_addr  = r_addr;
            bram_wdata = r_wdata;
        end
        // A requester that gave up mid-transaction gets no ack pulse.
        if (state == S_RESP) begin
            wbs_ack_o = ~grant & r0;
            p1_ack    = grant & r1;
        end
    end

    assign wbs_dat_o = rdata;
    assign p1_rdata  = rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: DELAYS=10 and DELAYS=0 instances, each with a
// behavioural read-before-write byte-lane BRAM.

module tb_bram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic        p1_req, p1_we, p1_ack;
    logic [3:0]  p1_be;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr, bram_wdata;
    logic [31:0] bram_rdata = 32'h0;

    logic        z_wbs_cyc_i = 1'b0, z_wbs_stb_i = 1'b0, z_wbs_we_i = 1'b0;
    logic [3:0]  z_wbs_sel_i = 4'h0;
    logic [31:0] z_wbs_adr_i = 32'h0, z_wbs_dat_i = 32'h0, z_wbs_dat_o;
    logic        z_wbs_ack_o;
    logic        z_p1_req, z_p1_we, z_p1_ack;
    logic [3:0]  z_p1_be;
    logic [31:0] z_p1_addr, z_p1_wdata, z_p1_rdata;
    logic        z_bram_en;
    logic [3:0]  z_bram_we;
    logic [31:0] z_bram_addr, z_bram_wdata;
    logic [31:0] z_bram_rdata = 32'h0;

    bram_arbiter #(.DELAYS(10), .BASE_HI(8'h38), .ADDR_W(22)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    bram_arbiter #(.DELAYS(0), .BASE_HI(8'h38), .ADDR_W(22)) u_dut_z (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(z_wbs_cyc_i), .wbs_stb_i(z_wbs_stb_i), .wbs_we_i(z_wbs_we_i),
        .wbs_sel_i(z_wbs_sel_i), .wbs_adr_i(z_wbs_adr_i), .wbs_dat_i(z_wbs_dat_i),
        .wbs_ack_o(z_wbs_ack_o), .wbs_dat_o(z_wbs_dat_o),
        .p1_req(z_p1_req), .p1_we(z_p1_we), .p1_be(z_p1_be), .p1_addr(z_p1_addr),
        .p1_wdata(z_p1_wdata), .p1_ack(z_p1_ack), .p1_rdata(z_p1_rdata),
        .bram_en(z_bram_en), .bram_we(z_bram_we), .bram_addr(z_bram_addr),
        .bram_wdata(z_bram_wdata), .bram_rdata(z_bram_rdata)
    );

    // Behavioural BRAMs keyed by the full word address, so unmasked upper bits would miss.
    logic [31:0] mem_a [logic [29:0]];
    logic [31:0] mem_z [logic [29:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_a(input logic [29:0] k);
        return mem_a.exists(k) ? mem_a[k] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_z(input logic [29:0] k);
        return mem_z.exists(k) ? mem_z[k] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (bram_en) begin
            bram_rdata <= rd_a(bram_addr[31:2]);
            mem_a[bram_addr[31:2]] = merge(rd_a(bram_addr[31:2]), bram_wdata, bram_we);
        end
        if (z_bram_en) begin
            z_bram_rdata <= rd_z(z_bram_addr[31:2]);
            mem_z[z_bram_addr[31:2]] = merge(rd_z(z_bram_addr[31:2]), z_bram_wdata, z_bram_we);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic [31:0] expz[$];
    int en_cnt = 0, z_en_cnt = 0;
    logic prev_en = 1'b0, z_prev_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses whenever an ack is presented.
    always @(negedge clk) begin
        if (wbs_ack_o) begin
            if (exp0.size() == 0) chk("wb_unexpected_ack", 32'h1, 32'h0);
            else chk("wb_rdata", wbs_dat_o, exp0.pop_front());
        end
        if (p1_ack) begin
            if (exp1.size() == 0) chk("p1_unexpected_ack", 32'h1, 32'h0);
            else chk("p1_rdata", p1_rdata, exp1.pop_front());
        end
        if (z_p1_ack) begin
            if (expz.size() == 0) chk("z_p1_unexpected_ack", 32'h1, 32'h0);
            else chk("z_p1_rdata", z_p1_rdata, expz.pop_front());
            chk("z_shared_rdata", z_wbs_dat_o, z_p1_rdata);
        end
        if (z_wbs_ack_o) chk("z_wb_unexpected_ack", 32'h1, 32'h0);
        if (bram_en) begin
            en_cnt++;
            chk("en_single_cycle", {31'h0, prev_en}, 32'h0);
            chk("bram_addr_masked", bram_addr & 32'hFFC0_0003, 32'h0);
        end
        if (z_bram_en) begin
            z_en_cnt++;
            chk("z_en_single_cycle", {31'h0, z_prev_en}, 32'h0);
        end
        prev_en   <= bram_en;
        z_prev_en <= z_bram_en;
    end

    task automatic wb_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [31:0] exp, output int lat);
        @(posedge clk); #1;
        exp0.push_back(exp);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        lat = 0;
        forever begin
            @(negedge clk);
            if (wbs_ack_o) break;
            lat++;
            if (lat > 200) begin
                chk("wb_ack_timeout", 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic p1_txn(input logic we, input logic [3:0] be, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [31:0] exp, output int lat);
        @(posedge clk); #1;
        exp1.push_back(exp);
        p1_req = 1'b1; p1_we = we; p1_be = be; p1_addr = adr; p1_wdata = dat;
        lat = 0;
        forever begin
            @(negedge clk);
            if (p1_ack) break;
            lat++;
            if (lat > 200) begin
                chk("p1_ack_timeout", 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk); #1;
        p1_req = 1'b0; p1_we = 1'b0;
    endtask

    task automatic z_txn(input logic we, input logic [3:0] be, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [31:0] exp, output int lat);
        @(posedge clk); #1;
        expz.push_back(exp);
        z_p1_req = 1'b1; z_p1_we = we; z_p1_be = be; z_p1_addr = adr; z_p1_wdata = dat;
        lat = 0;
        forever begin
            @(negedge clk);
            if (z_p1_ack) break;
            lat++;
            if (lat > 200) begin
                chk("z_ack_timeout", 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk); #1;
        z_p1_req = 1'b0; z_p1_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, n, e0;
        rst_n = 1'b0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        p1_req = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wdata = 0;
        z_p1_req = 0; z_p1_we = 0; z_p1_be = 0; z_p1_addr = 0; z_p1_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_bram_en", {31'h0, bram_en}, 32'h0);
        chk("rst_acks", {30'h0, wbs_ack_o, p1_ack}, 32'h0);
        chk("rst_rdata", wbs_dat_o, 32'h0);
        chk("rst_bram_addr", bram_addr, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // WB write then read back, with the reference latency
        wb_txn(1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 32'h0, l0);
        chk("wb_write_lat", l0, 13);
        wb_txn(1'b0, 4'hF, 32'h3800_0010, 32'h0, 32'hDEAD_BEEF, l0);
        chk("wb_read_lat", l0, 13);

        // Partial byte-lane write
        wb_txn(1'b1, 4'hF, 32'h3800_0020, 32'h1122_3344, 32'h0, l0);
        wb_txn(1'b1, 4'b0010, 32'h3800_0020, 32'h0000_AA00, 32'h1122_3344, l0);
        wb_txn(1'b0, 4'hF, 32'h3800_0020, 32'h0, 32'h1122_AA44, l0);

        // First tie after reset: port 0 wins, port 1 follows 14 cycles later
        fork
            wb_txn(1'b1, 4'hF, 32'h3800_0030, 32'hCAFE_0000, 32'h0, l0);
            p1_txn(1'b0, 4'hF, 32'h0000_0030, 32'h0, 32'hCAFE_0000, l1);
        join
        chk("tie1_p0_lat", l0, 13);
        chk("tie1_p1_lat", l1, 27);
        // Second tie: port 1 wins, so port 0 reads the word port 1 just wrote
        fork
            wb_txn(1'b0, 4'hF, 32'h3800_0030, 32'h0, 32'h1234_5678, l0);
            p1_txn(1'b1, 4'hF, 32'h0000_0030, 32'h1234_5678, 32'hCAFE_0000, l1);
        join
        chk("tie2_p1_lat", l1, 13);
        chk("tie2_p0_lat", l0, 27);

        // DELAYS=0 instance
        z_txn(1'b1, 4'hF, 32'h0000_0040, 32'h55AA_55AA, 32'h0, l1);
        chk("z_write_lat", l1, 3);
        z_txn(1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'h55AA_55AA, l1);
        chk("z_read_lat", l1, 3);
        chk("z_en_cycles", z_en_cnt, 2);

        // WB address outside the window is ignored; port 1 proceeds
        e0 = en_cnt;
        n = 0;
        fork
            begin
                @(posedge clk); #1;
                wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
                wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'hFFFF_FFFF;
                repeat (40) begin
                    @(negedge clk);
                    if (wbs_ack_o) n++;
                end
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
            end
            p1_txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, l1);
        join
        chk("offwindow_no_ack", n, 0);
        chk("offwindow_en_cycles", en_cnt - e0, 1);
        chk("offwindow_p1_lat", l1, 13);

        // Aliasing above 4 MB and ignored byte offset
        p1_txn(1'b1, 4'hF, 32'h0040_0050, 32'h0BAD_F00D, 32'h0, l1);
        wb_txn(1'b0, 4'hF, 32'h38C0_0050, 32'h0, 32'h0BAD_F00D, l0);
        p1_txn(1'b0, 4'hF, 32'h0000_0053, 32'h0, 32'h0BAD_F00D, l1);

        // Requester drops mid-transaction: write lands, no ack
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_be = 4'hF; p1_addr = 32'h70; p1_wdata = 32'hABCD_0123;
        repeat (3) @(negedge clk);
        p1_req = 1'b0; p1_we = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (p1_ack) n++;
        end
        chk("dropped_no_ack", n, 0);
        p1_txn(1'b0, 4'hF, 32'h0000_0070, 32'h0, 32'hABCD_0123, l1);

        // Reset during WAIT
        wb_txn(1'b1, 4'hF, 32'h3800_0060, 32'h600D_CAFE, 32'h0, l0);
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b0; p1_be = 4'hF; p1_addr = 32'h60;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_acks", {30'h0, wbs_ack_o, p1_ack}, 32'h0);
        chk("midrst_bram_en_we", {27'h0, bram_en, bram_we}, 32'h0);
        chk("midrst_bram_addr", bram_addr, 32'h0);
        chk("midrst_bram_wdata", bram_wdata, 32'h0);
        chk("midrst_rdata", p1_rdata, 32'h0);
        p1_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        wb_txn(1'b0, 4'hF, 32'h3800_0060, 32'h0, 32'h600D_CAFE, l0);
        chk("post_rst_lat", l0, 13);

        // Read data holds between acks and is shared by both ports
        repeat (5) @(negedge clk);
        chk("hold_p1_rdata", p1_rdata, 32'h600D_CAFE);
        chk("hold_wb_rdata", wbs_dat_o, 32'h600D_CAFE);

        repeat (3) @(negedge clk);
        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);
        chk("expz_drained", expz.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
